// File: rtl/irq_encoder8to3_if.sv
// Request/index-stream bundle for irq_encoder8to3.
// master = encoder side (drives the presented code), slave = requester/consumer side.
interface irq_encoder8to3_if;
    logic [7:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    modport master (
        input  req,
        input  ack,
        output code,
        output valid,
        output pending,
        output overrun
    );

    modport slave (
        output req,
        output ack,
        input  code,
        input  valid,
        input  pending,
        input  overrun
    );
endinterface

// File: rtl/irq_encoder8to3.sv
// 8-to-3 priority encoder with sticky request capture and a valid/ack handshake.
// The presented code is held until accepted; there is no preemption.
module irq_encoder8to3 #(
    parameter bit HIGH_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    irq_encoder8to3_if.master         bus
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] code_q, code_d;
    logic       overrun_q, overrun_d;

    logic       accept;
    logic [7:0] clr;
    logic [2:0] sel;

    // ack only counts while a code is presented, so an X on ack in idle is masked here.
    assign accept    = (state_q == StPresent) & bus.ack;
    assign clr       = accept ? (8'd1 << code_q) : 8'd0;
    // Set wins over clear: a fresh req on the accepted bit keeps it pending.
    assign pending_d = (pending_q & ~clr) | bus.req;
    assign overrun_d = |(bus.req & pending_q & ~clr);

    always_comb begin
        sel = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (pending_d[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_d[i]) sel = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (|pending_d) begin
                    code_d  = sel;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (accept) begin
                    if (|pending_d) begin
                        code_d = sel;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.code    = code_q;
    assign bus.valid   = (state_q == StPresent);
    assign bus.pending = pending_q;
    assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_irq_encoder8to3.sv
// Directed bench for irq_encoder8to3: one instance per priority order, shared stimulus.
module tb_irq_encoder8to3;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       ack;

    int n_checks;
    int n_pass;

    irq_encoder8to3_if bus_hi ();
    irq_encoder8to3_if bus_lo ();

    assign bus_hi.req = req;
    assign bus_hi.ack = ack;
    assign bus_lo.req = req;
    assign bus_lo.ack = ack;

    irq_encoder8to3 #(.HIGH_FIRST(1'b1)) u_dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (bus_hi)
    );

    irq_encoder8to3 #(.HIGH_FIRST(1'b0)) u_dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (bus_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_hi[4];
    int exp_lo[4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        exp_hi   = '{7, 5, 2, 0};
        exp_lo   = '{0, 2, 5, 7};
        rst = 1'b1;
        req = 8'h00;
        ack = 1'b0;
        #12;
        check("reset_valid", {7'd0, bus_hi.valid}, 8'd0);
        check("reset_pending", bus_hi.pending, 8'h00);
        check("reset_code", {5'd0, bus_hi.code}, 8'd0);
        check("reset_overrun", {7'd0, bus_hi.overrun}, 8'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic capture and accept.
        req = 8'h01;
        tick();
        req = 8'h00;
        ack = 1'b1;
        check("basic_valid", {7'd0, bus_hi.valid}, 8'd1);
        check("basic_code", {5'd0, bus_hi.code}, 8'd0);
        check("basic_pending", bus_hi.pending, 8'h01);
        tick();
        check("basic_valid_after_ack", {7'd0, bus_hi.valid}, 8'd0);
        check("basic_pending_after_ack", bus_hi.pending, 8'h00);
        ack = 1'b0;
        tick();

        // Priority order, back-to-back accepts.
        req = 8'hA5;
        ack = 1'b1;
        tick();
        req = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check("a5_hi_valid", {7'd0, bus_hi.valid}, 8'd1);
            check("a5_hi_code", {5'd0, bus_hi.code}, 8'(exp_hi[i]));
            check("a5_lo_valid", {7'd0, bus_lo.valid}, 8'd1);
            check("a5_lo_code", {5'd0, bus_lo.code}, 8'(exp_lo[i]));
            tick();
        end
        check("a5_hi_done", {7'd0, bus_hi.valid}, 8'd0);
        check("a5_lo_done", {7'd0, bus_lo.valid}, 8'd0);
        check("a5_hi_pending", bus_hi.pending, 8'h00);
        ack = 1'b0;
        tick();

        // No preemption.
        req = 8'h04;
        tick();
        req = 8'h00;
        check("np_code_first", {5'd0, bus_hi.code}, 8'd2);
        tick();
        req = 8'h80;
        tick();
        req = 8'h00;
        check("np_code_held", {5'd0, bus_hi.code}, 8'd2);
        check("np_pending_84", bus_hi.pending, 8'h84);
        check("np_no_overrun", {7'd0, bus_hi.overrun}, 8'd0);
        tick();
        check("np_code_still", {5'd0, bus_hi.code}, 8'd2);
        ack = 1'b1;
        tick();
        check("np_code_next", {5'd0, bus_hi.code}, 8'd7);
        check("np_valid_next", {7'd0, bus_hi.valid}, 8'd1);
        check("np_pending_80", bus_hi.pending, 8'h80);
        tick();
        check("np_valid_done", {7'd0, bus_hi.valid}, 8'd0);
        check("np_pending_00", bus_hi.pending, 8'h00);
        ack = 1'b0;
        tick();

        // Overrun and set-wins.
        req = 8'h08;
        tick();
        check("ov_code", {5'd0, bus_hi.code}, 8'd3);
        check("ov_quiet", {7'd0, bus_hi.overrun}, 8'd0);
        tick();
        req = 8'h00;
        check("ov_pulse", {7'd0, bus_hi.overrun}, 8'd1);
        check("ov_pending", bus_hi.pending, 8'h08);
        tick();
        check("ov_pulse_end", {7'd0, bus_hi.overrun}, 8'd0);
        ack = 1'b1;
        req = 8'h08;
        tick();
        req = 8'h00;
        check("sw_valid", {7'd0, bus_hi.valid}, 8'd1);
        check("sw_code", {5'd0, bus_hi.code}, 8'd3);
        check("sw_pending", bus_hi.pending, 8'h08);
        check("sw_no_overrun", {7'd0, bus_hi.overrun}, 8'd0);
        tick();
        check("sw_done", {7'd0, bus_hi.valid}, 8'd0);

        // ack high or unknown while idle has no effect.
        tick();
        ack = 1'bx;
        tick();
        tick();
        check("x_ack_valid", {7'd0, bus_hi.valid}, 8'd0);
        check("x_ack_pending", bus_hi.pending, 8'h00);
        ack = 1'b0;
        tick();

        // Asynchronous reset between edges.
        req = 8'hFF;
        tick();
        req = 8'h00;
        check("ar_pre_valid", {7'd0, bus_hi.valid}, 8'd1);
        check("ar_pre_pending", bus_hi.pending, 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", {7'd0, bus_hi.valid}, 8'd0);
        check("ar_pending", bus_hi.pending, 8'h00);
        check("ar_code", {5'd0, bus_hi.code}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("ar_stays_idle", {7'd0, bus_hi.valid}, 8'd0);

        // One-hot sweep, decoded back to one-hot.
        ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] onehot;
            onehot = 8'd1 << i;
            req = onehot;
            tick();
            req = 8'h00;
            check("sweep_hi_code", {5'd0, bus_hi.code}, 8'(i));
            check("sweep_lo_code", {5'd0, bus_lo.code}, 8'(i));
            check("sweep_decode", 8'd1 << bus_hi.code, onehot);
            tick();
            check("sweep_idle", {7'd0, bus_hi.valid}, 8'd0);
        end
        ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_encoder8to3.md
Name: irq_encoder8to3

Overview:
- Sequential counterpart to the team's combinational 3-to-8 decoder: an 8-to-3 priority encoder with request capture and a valid/ack handshake.
- Eight request lines are captured into sticky pending bits.
- The highest-priority pending index is presented as a 3-bit code and held until a consumer acknowledges it; the acknowledged bit is then cleared.
- Used to turn one-hot event lines into a binary index stream, e.g. to drive the 3-to-8 decoder on the far side of a narrow link.

Parameters:
- HIGH_FIRST, 1, priority order: 1 = bit 7 highest priority, 0 = bit 0 highest priority.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  8  request lines; a bit sampled high at a clock edge sets the matching pending bit.
- ack  input  1  consumer accepts the presented code; qualified by valid.
- code  output  3  index of the presented request; meaningful only while valid = 1.
- valid  output  1  code is presented and stable.
- pending  output  8  current sticky pending register, for debug and status.
- overrun  output  1  one-cycle pulse: a req bit arrived while its pending bit was already set.

Behaviour:
- Reset (async assert, sync-safe deassert): pending = 8'h00, code = 3'd0, valid = 0, overrun = 0, FSM = IDLE.
- All outputs are registered. No combinational path from req or ack to any output.
- Definitions:
  - Accept = valid & ack at a clock edge.
  - clr = one-hot(code) if Accept, else 0.
  - pending_next = (pending & ~clr) | req.
- Set wins: if req sets the same bit that Accept clears in the same cycle, the bit stays pending and is presented again later.
- Priority: sel = index of the highest-priority 1 in pending_next, ordered per HIGH_FIRST.
- FSM IDLE (valid = 0):
  - At each edge, if pending_next != 0: code <= sel, valid <= 1, go to PRESENT.
  - Otherwise remain in IDLE.
  - Latency: req high at edge k gives valid = 1 after edge k (visible in cycle k+1).
- FSM PRESENT (valid = 1):
  - No Accept: code is held, even if a higher-priority request arrives. There is no preemption.
  - Accept and pending_next != 0: code <= sel, valid stays 1. Back-to-back, no bubble.
  - Accept and pending_next == 0: valid <= 0, go to IDLE. code keeps its last value.
- ack while valid = 0 is ignored: no state change, no bit cleared.
- overrun <= |(req & pending & ~clr) at every edge, so it pulses for one cycle.
  - The request is still recorded as a single pending event. There is no counting per bit.
- Reset asserted mid-handshake: all state clears immediately, including pending requests and a presented code.
  - After release, req must be sampled again before anything is presented.
- X on ack while valid = 0 must not corrupt state.

Test Plan:
- Reset, then req = 8'h01 for 1 cycle, then ack held high -> valid = 1 with code = 3'd0 one edge after capture; after the Accept edge valid = 0, pending = 8'h00.
- HIGH_FIRST = 1, single-cycle req = 8'hA5, ack held high -> codes 7, 5, 2, 0 on consecutive cycles with valid high throughout, then valid = 0. With HIGH_FIRST = 0, same stimulus -> codes 0, 2, 5, 7.
- No preemption: req = 8'h04, hold ack = 0 for 3 cycles, pulse req = 8'h80 during the hold -> code stays 2 until ack; next code = 7; pending shows 8'h84, then 8'h80, then 8'h00.
- Overrun and set-wins: with bit 3 pending and unacked, pulse req[3] -> overrun pulses once, pending[3] stays 1. In the Accept cycle for code 3, also drive req[3] -> valid stays 1 and code = 3 is presented again.
- Async reset mid-operation: with pending = 8'hFF and valid = 1, assert rst between clock edges -> valid = 0, pending = 8'h00, code = 0 without waiting for a clock edge. With no new req after release, valid stays 0.
- Exhaustive one-hot sweep: for each i = 0..7, single req bit i with ack held high -> code = i. Feeding code into the team's 3-to-8 decoder reproduces one-hot bit i.
